pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register for the in-order CPU pipeline. It replaces hard-wired inter-stage latches, such as the decode-to-execute stage, with a valid/ready handshake, an optional two-entry skid buffer, a synchronous flush that inserts bubbles, and a saturating stall-cycle counter. One instance sits between each pair of adjacent pipeline stages. The payload is an opaque packed bundle (operands, destination register, write enable, opcode, immediate, shift amount), so one module serves every stage boundary.

## Interface
- DATA_W, 128: payload width in bits; legal range 1 or more.
- SKID, 1: 1 = two-entry skid buffer with registered `up_ready_o`; 0 = single register with combinational ready.
- CNT_W, 32: stall counter width; legal range 1 or more.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; discards all held and incoming beats.
- up_valid_i  in  1  upstream beat valid.
- up_data_i  in  DATA_W  upstream payload.
- up_ready_o  out  1  stage can accept a beat this cycle.
- dn_valid_o  out  1  output beat valid.
- dn_data_o  out  DATA_W  output payload.
- dn_ready_i  in  1  downstream accepts the beat this cycle.
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Handshakes:
  - Upstream transfer when `up_valid_i & up_ready_o`.
  - Downstream transfer when `dn_valid_o & dn_ready_i`.
- Internal state: main register (mv, md) drives `dn_*`; skid register (sv, sd) exists only when SKID=1.
- States: EMPTY (mv=0, sv=0), BUSY (mv=1, sv=0), FULL (mv=1, sv=1).
- SKID=1 transitions:
  - EMPTY + upstream transfer → BUSY; md ← up_data_i.
  - BUSY + upstream transfer + downstream transfer → BUSY; md ← up_data_i.
  - BUSY + downstream transfer only → EMPTY.
  - BUSY + upstream transfer only → FULL; sd ← up_data_i.
  - FULL + downstream transfer → BUSY; md ← sd.
  - FULL otherwise → hold.
  - `up_ready_o = ~sv`, driven from a flop, so there is no combinational path from `dn_ready_i` to `up_ready_o`.
- SKID=0:
  - `up_ready_o = ~mv | dn_ready_i` (combinational).
  - FULL is unreachable.
  - Transitions are as above, minus the skid paths.
- Ordering: beats leave in strict arrival order. No beat is duplicated or lost except on flush or reset.
- Flush:
  - On the next edge, mv and sv clear, and md and sd load all-zero (the NOP encoding), so `dn_data_o` reads zero while invalid.
  - An upstream beat presented in the flush cycle is discarded, but still counts as a handshake for the upstream stage.
  - A downstream transfer in the flush cycle is delivered; downstream owns it.
- Stall counter: increments each cycle with `dn_valid_o & ~dn_ready_i`; saturates at all-ones. Flush does not clear it; only `rst` does.
- Reset (asynchronous, any time): mv=sv=0, md=sd=0, `stall_cnt_o`=0. Consequently `dn_valid_o`=0, `dn_data_o`=0, and `up_ready_o`=1 in both SKID modes.

## Timing
- Latency: 1 cycle from upstream transfer to `dn_valid_o`, when the stage was EMPTY or draining.
- Throughput: 1 beat/cycle sustained in both modes.
- Stability: `dn_data_o` and `dn_valid_o` are stable while `dn_valid_o & ~dn_ready_i`.
- SKID=1 back-pressure: after `dn_ready_i` drops, at most one further beat is accepted (into skid). `up_ready_o` falls on the following edge.
- Simultaneous flush and upstream transfer: flush wins; the state is EMPTY next cycle.
- Reset release: first acceptance is possible on the first rising edge after `rst` deasserts.

## Structure
- Shared package `pipe_pkg`:
  - state encoding typedef: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10;
  - NOP payload constant (all zero);
  - `RstEnable`-style polarity constant for `rst`.
- Sub-module `sat_counter` (parameter CNT_W; inputs inc, rst; output count) implements the stall counter.
- The skid path is generated only when SKID=1.

## Test plan
- **Streaming:** SKID=1; 8 beats 0x1..0x8 on consecutive cycles with `dn_ready_i`=1 → `dn_data_o` shows 0x1..0x8 one cycle later, no gaps; `stall_cnt_o`=0.
- **Skid fill:** SKID=1, BUSY holding 0xA; `dn_ready_i`=0; send 0xB → state FULL, `up_ready_o`=0 next cycle. Raise `dn_ready_i` → 0xA then 0xB delivered; `stall_cnt_o` equals the held cycles.
- **Flush:** FULL holding 0xA/0xB, `up_valid_i` with 0xC, `flush_i`=1 → next cycle `dn_valid_o`=0 and `dn_data_o`=0. 0xA, 0xB and 0xC are never delivered.
- **Combinational ready:** SKID=0, mv=1, toggle `dn_ready_i` → `up_ready_o` follows in the same cycle; no beat is ever lost.
- **Counter saturation:** CNT_W=3; hold back-pressure for 10 cycles → `stall_cnt_o`=7 and stays 7.
- **Async reset:** assert `rst` mid-cycle while FULL → `dn_valid_o`=0, `up_ready_o`=1 and `stall_cnt_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   stage_state_t : occupancy encoding of a stage (EMPTY/BUSY/FULL)
//   RST_ENABLE    : active level of the asynchronous reset
//   NOP_BIT       : fill bit of the NOP payload (all-zero encoding)
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } stage_state_t;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, clears count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and saturating stall-cycle counter.
//   clk, rst            : clock and asynchronous active-high reset
//   flush_i             : drop all held and incoming beats on next edge
//   up_valid_i/up_data_i/up_ready_o : upstream handshake and payload
//   dn_valid_o/dn_data_o/dn_ready_i : downstream handshake and payload
//   stall_cnt_o         : cycles spent with dn_valid_o & ~dn_ready_i
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [DATA_W-1:0] NOP_DATA = {DATA_W{NOP_BIT}};

    logic              mv;
    logic              sv;
    logic [DATA_W-1:0] md;
    logic [DATA_W-1:0] sd;
    logic              up_xfer;
    logic              dn_xfer;
    stage_state_t      st;

    assign up_xfer = up_valid_i & up_ready_o;
    assign dn_xfer = mv & dn_ready_i;

    always_comb begin
        st = EMPTY;
        if (sv) begin
            st = FULL;
        end else if (mv) begin
            st = BUSY;
        end
    end

    // Main register: always the head of the stage, drives the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            mv <= 1'b0;
            md <= NOP_DATA;
        end else if (flush_i) begin
            mv <= 1'b0;
            md <= NOP_DATA;
        end else begin
            case (st)
                EMPTY: begin
                    if (up_xfer) begin
                        mv <= 1'b1;
                        md <= up_data_i;
                    end
                end
                BUSY: begin
                    if (up_xfer && dn_xfer) begin
                        md <= up_data_i;
                    end else if (dn_xfer) begin
                        mv <= 1'b0;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        md <= sd;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (SKID) begin : g_skid
            // Ready comes straight from the skid flop, so dn_ready_i never
            // reaches up_ready_o combinationally; the skid entry absorbs the
            // one beat accepted in the cycle back-pressure appears.
            always_ff @(posedge clk or posedge rst) begin
                if (rst == RST_ENABLE) begin
                    sv <= 1'b0;
                    sd <= NOP_DATA;
                end else if (flush_i) begin
                    sv <= 1'b0;
                    sd <= NOP_DATA;
                end else if ((st == BUSY) && up_xfer && !dn_xfer) begin
                    sv <= 1'b1;
                    sd <= up_data_i;
                end else if ((st == FULL) && dn_xfer) begin
                    sv <= 1'b0;
                end
            end
            assign up_ready_o = ~sv;
        end else begin : g_noskid
            assign sv         = 1'b0;
            assign sd         = NOP_DATA;
            assign up_ready_o = ~mv | dn_ready_i;
        end
    endgenerate

    assign dn_valid_o = mv;
    assign dn_data_o  = md;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (mv & ~dn_ready_i),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance driven by the
// same stimulus, each compared against a small FIFO-occupancy model.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fl;
    logic          uv;
    logic [DW-1:0] ud;
    logic          dr;

    logic          ur0, dv0, ur1, dv1;
    logic [DW-1:0] dd0, dd1;
    logic [2:0]    sc0;
    logic [7:0]    sc1;

    int checks = 0;
    int errors = 0;

    // Model: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    int            occ  [2];
    logic [DW-1:0] ent  [2][2];
    bit            dz   [2];
    int            cnt  [2];
    int            cmax [2];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .flush_i(fl), .up_valid_i(uv), .up_data_i(ud),
        .up_ready_o(ur0), .dn_valid_o(dv0), .dn_data_o(dd0), .dn_ready_i(dr),
        .stall_cnt_o(sc0)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .flush_i(fl), .up_valid_i(uv), .up_data_i(ud),
        .up_ready_o(ur1), .dn_valid_o(dv1), .dn_data_o(dd1), .dn_ready_i(dr),
        .stall_cnt_o(sc1)
    );

    function automatic bit exp_ready(int k);
        if (k == 1) return (occ[1] < 2);
        return (occ[0] == 0) || dr;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            occ[k] = 0;
            dz[k]  = 1'b1;
            cnt[k] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic          o_ur, o_dv;
            logic [DW-1:0] o_dd;
            logic [31:0]   o_sc;
            o_ur = (k == 1) ? ur1 : ur0;
            o_dv = (k == 1) ? dv1 : dv0;
            o_dd = (k == 1) ? dd1 : dd0;
            o_sc = (k == 1) ? 32'(sc1) : 32'(sc0);
            chk($sformatf("ready%0d", k), 32'(o_ur), 32'(exp_ready(k)));
            chk($sformatf("valid%0d", k), 32'(o_dv), 32'(occ[k] > 0));
            if (occ[k] > 0)
                chk($sformatf("data%0d", k), 32'(o_dd), 32'(ent[k][0]));
            else if (dz[k])
                chk($sformatf("nopdata%0d", k), 32'(o_dd), 32'h0);
            chk($sformatf("stall%0d", k), o_sc, 32'(cnt[k]));
        end
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic update_model();
        for (int k = 0; k < 2; k++) begin
            bit rdy, upx, dnx;
            if (rst) begin
                occ[k] = 0;
                dz[k]  = 1'b1;
                cnt[k] = 0;
            end else begin
                rdy = exp_ready(k);
                upx = uv && rdy;
                dnx = (occ[k] > 0) && dr;
                if ((occ[k] > 0) && !dr && (cnt[k] < cmax[k])) cnt[k]++;
                if (fl) begin
                    occ[k] = 0;
                    dz[k]  = 1'b1;
                end else begin
                    if (dnx) begin
                        ent[k][0] = ent[k][1];
                        occ[k]--;
                    end
                    if (upx) begin
                        ent[k][occ[k]] = ud;
                        occ[k]++;
                        dz[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic r, input logic f);
        uv = v;
        ud = d;
        dr = r;
        fl = f;
        #4;
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        uv  = 1'b0;
        ud  = '0;
        dr  = 1'b0;
        fl  = 1'b0;
        cmax[0] = 7;
        cmax[1] = 255;
        model_reset();

        // Reset state.
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
        rst = 1'b0;

        // Streaming 0x1..0x8 with downstream always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Skid fill: A held, B goes to skid, then drain A, B.
        step(1'b1, 16'h000A, 1'b1, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL with C offered upstream.
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b0, 1'b1);
        chk("flush_valid1", 32'(dv1), 32'h0);
        chk("flush_data1", 32'(dd1), 32'h0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Combinational ready on the SKID=0 instance while it holds a beat.
        step(1'b1, 16'h0055, 1'b1, 1'b0);
        uv = 1'b0;
        dr = 1'b0;
        #1;
        chk("comb_ready_lo", 32'(ur0), 32'h0);
        dr = 1'b1;
        #1;
        chk("comb_ready_hi", 32'(ur0), 32'h1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Counter saturation on the 3-bit counter.
        step(1'b1, 16'h0077, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("sat_cnt0", 32'(sc0), 32'h7);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("sat_hold0", 32'(sc0), 32'h7);
        step(1'b0, '0, 1'b1, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset mid-cycle while the SKID=1 instance is FULL.
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 16'h00B2, 1'b0, 1'b0);
        uv = 1'b0;
        #2;
        chk("pre_rst_full1", 32'(ur1), 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_valid1", 32'(dv1), 32'h0);
        chk("async_ready1", 32'(ur1), 32'h1);
        chk("async_stall1", 32'(sc1), 32'h0);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
        rst = 1'b0;

        // Acceptance on the first edge after reset release.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b1, 16'h5678, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
